onchip_mem_arbiter: RTL and testbench

- Two-master Avalon-MM arbiter in front of the 5000-word single-port on-chip RAM (32-bit, 13-bit word address, byte enables, 1-cycle read latency).
- Lets the Nios data master (m0) and a DMA/PIO-side master (m1) share the one RAM port with round-robin fairness.
- Contains a clear engine that zero-fills the whole RAM on request.
- Sits between the interconnect masters and the RAM's chipselect/write/address port.

---
 rtl/onchip_mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_onchip_mem_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/onchip_mem_arbiter.sv
// Two-master round-robin Avalon-MM arbiter for a single-port on-chip RAM,
// with a built-in engine that zero-fills the whole RAM on request.
module onchip_mem_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 5000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  input  logic                clear_start,
  output logic                clear_busy,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  input  logic [DATA_W-1:0]   mem_readdata
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {S_IDLE, S_CLEAR} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic                last_grant_q, last_grant_d;  // 1: m1 was granted last
  logic                rd_valid_q, rd_valid_d;
  logic                rd_owner_q, rd_owner_d;      // 1: read belongs to m1
  logic                rd_oor_q, rd_oor_d;

  logic                req0, req1, grant0, grant1;
  logic [ADDR_W-1:0]   sel_addr;
  logic [BE_W-1:0]     sel_be;
  logic [DATA_W-1:0]   sel_wd;
  logic                sel_read, sel_write, sel_oor;

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d        = state_q;
    clr_cnt_d      = clr_cnt_q;
    last_grant_d   = last_grant_q;
    rd_valid_d     = 1'b0;
    rd_owner_d     = 1'b0;
    rd_oor_d       = 1'b0;
    grant0         = 1'b0;
    grant1         = 1'b0;
    mem_address    = '0;
    mem_byteenable = '0;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    mem_writedata  = '0;

    req0 = m0_read | m0_write;
    req1 = m1_read | m1_write;

    unique case (state_q)
      S_IDLE: begin
        if (req0 && req1) begin
          grant0 = last_grant_q;
          grant1 = ~last_grant_q;
        end else begin
          grant0 = req0;
          grant1 = req1;
        end
        if (clear_start) begin
          state_d   = S_CLEAR;
          clr_cnt_d = '0;
        end
      end
      S_CLEAR: begin
        mem_chipselect = 1'b1;
        mem_write      = 1'b1;
        mem_address    = clr_cnt_q;
        mem_byteenable = '1;
        if (clr_cnt_q == LAST_ADDR) begin
          state_d   = S_IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    sel_addr  = grant1 ? m1_address    : m0_address;
    sel_be    = grant1 ? m1_byteenable : m0_byteenable;
    sel_wd    = grant1 ? m1_writedata  : m0_writedata;
    sel_read  = grant1 ? m1_read       : m0_read;
    sel_write = grant1 ? m1_write      : m0_write;
    sel_oor   = sel_addr > LAST_ADDR;

    if (grant0 || grant1) begin
      last_grant_d = grant1;
      // Out-of-range writes are acknowledged but never reach the RAM.
      if (!sel_oor) begin
        mem_chipselect = 1'b1;
        mem_write      = sel_write;
        mem_address    = sel_addr;
        mem_byteenable = sel_be;
        mem_writedata  = sel_wd;
      end
      if (sel_read && !sel_write) begin
        rd_valid_d = 1'b1;
        rd_owner_d = grant1;
        rd_oor_d   = sel_oor;
      end
    end

    m0_waitrequest = req0 & ~grant0;
    m1_waitrequest = req1 & ~grant1;
  end

  // NOTE: state is updated only with non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      clr_cnt_q    <= '0;
      last_grant_q <= 1'b1;
      rd_valid_q   <= 1'b0;
      rd_owner_q   <= 1'b0;
      rd_oor_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      last_grant_q <= last_grant_d;
      rd_valid_q   <= rd_valid_d;
      rd_owner_q   <= rd_owner_d;
      rd_oor_q     <= rd_oor_d;
    end
  end

  assign clear_busy       = (state_q == S_CLEAR);
  assign m0_readdatavalid = rd_valid_q & ~rd_owner_q;
  assign m1_readdatavalid = rd_valid_q &  rd_owner_q;
  assign m0_readdata      = (m0_readdatavalid && !rd_oor_q) ? mem_readdata : '0;
  assign m1_readdata      = (m1_readdatavalid && !rd_oor_q) ? mem_readdata : '0;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed bench for onchip_mem_arbiter: a vector table for arbitration and
// range handling, plus hand-written sequences for byte lanes, clear and reset.
module tb_onchip_mem_arbiter;

  localparam int DEPTH = 5000;

  logic        clk = 1'b0;
  logic        reset;
  logic [12:0] m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic        clear_start, clear_busy;
  logic [12:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write;
  logic [31:0] mem_writedata, mem_readdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  onchip_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .clear_start(clear_start), .clear_busy(clear_busy),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata)
  );

  // Behavioural single-port RAM with byte lanes and one-cycle read latency.
  logic [31:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_chipselect && int'(mem_address) < DEPTH) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[int'(mem_address)][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_readdata <= ram[int'(mem_address)];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        m0_rd, m0_wr; logic [12:0] m0_addr; logic [31:0] m0_wd;
    logic        m1_rd, m1_wr; logic [12:0] m1_addr; logic [31:0] m1_wd;
    logic        e_w0, e_w1, e_cs, e_we; logic [12:0] e_addr; logic [31:0] e_wd;
    logic        e_rv0, e_rv1; logic [31:0] e_rd0, e_rd1;
  } vec_t;

  function automatic vec_t mk(
      input logic r0, w0, input logic [12:0] a0, input logic [31:0] d0,
      input logic r1, w1, input logic [12:0] a1, input logic [31:0] d1,
      input logic ew0, ew1, ecs, ewe, input logic [12:0] ea, input logic [31:0] ewd,
      input logic rv0, rv1, input logic [31:0] rd0, rd1);
    vec_t v;
    v.m0_rd = r0; v.m0_wr = w0; v.m0_addr = a0; v.m0_wd = d0;
    v.m1_rd = r1; v.m1_wr = w1; v.m1_addr = a1; v.m1_wd = d1;
    v.e_w0 = ew0; v.e_w1 = ew1; v.e_cs = ecs; v.e_we = ewe; v.e_addr = ea; v.e_wd = ewd;
    v.e_rv0 = rv0; v.e_rv1 = rv1; v.e_rd0 = rd0; v.e_rd1 = rd1;
    return v;
  endfunction

  task automatic idle_masters();
    m0_read = 0; m0_write = 0; m0_address = '0; m0_byteenable = 4'hF; m0_writedata = '0;
    m1_read = 0; m1_write = 0; m1_address = '0; m1_byteenable = 4'hF; m1_writedata = '0;
  endtask

  task automatic m0_wr_cycle(input logic [12:0] a, input logic [31:0] d);
    @(negedge clk);
    idle_masters();
    m0_write = 1; m0_address = a; m0_writedata = d;
    #2 check("fill_wait", m0_waitrequest, 0);
  endtask

  // Follows a running sweep from the current sample point; returns busy-cycle count.
  task automatic run_sweep(input int start, input int glitch_at, input logic hold_rd,
                           output int n, output int bad);
    n = start; bad = 0;
    while (clear_busy && n < 6000) begin
      if (!mem_chipselect || !mem_write || mem_address != 13'(n) ||
          mem_byteenable != 4'hF || mem_writedata != 32'h0) bad++;
      if (hold_rd && !m0_waitrequest) bad++;
      clear_start = (n == glitch_at);
      @(negedge clk);
      clear_start = 0;
      #2 n++;
    end
  endtask

  vec_t vecs[20];
  int   n, bad;

  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = '0;
    idle_masters();
    clear_start = 0;
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;

    //            m0: rd wr addr  wdata        m1: rd wr addr  wdata         w0 w1 cs we addr  wdata         rv0 rv1 rd0           rd1
    vecs[0]  = mk(0, 0, 0,  0,             0, 0, 0,    0,             0, 0, 0, 0, 0,  0,             0, 0, 0,            0);
    vecs[1]  = mk(0, 1, 10, 32'hA5A5_0001, 0, 1, 10,   32'hA5A5_0002, 0, 1, 1, 1, 10, 32'hA5A5_0001, 0, 0, 0,            0);
    vecs[2]  = mk(0, 0, 0,  0,             0, 1, 10,   32'hA5A5_0002, 0, 0, 1, 1, 10, 32'hA5A5_0002, 0, 0, 0,            0);
    vecs[3]  = mk(1, 0, 10, 0,             0, 0, 0,    0,             0, 0, 1, 0, 10, 0,             0, 0, 0,            0);
    vecs[4]  = mk(0, 0, 0,  0,             0, 1, 11,   32'h0000_0011, 0, 0, 1, 1, 11, 32'h0000_0011, 1, 0, 32'hA5A5_0002, 0);
    vecs[5]  = mk(1, 0, 10, 0,             1, 0, 11,   0,             0, 1, 1, 0, 10, 0,             0, 0, 0,            0);
    vecs[6]  = mk(1, 0, 11, 0,             1, 0, 11,   0,             1, 0, 1, 0, 11, 0,             1, 0, 32'hA5A5_0002, 0);
    vecs[7]  = mk(1, 0, 11, 0,             1, 0, 10,   0,             0, 1, 1, 0, 11, 0,             0, 1, 0,            32'h11);
    vecs[8]  = mk(1, 0, 10, 0,             1, 0, 10,   0,             1, 0, 1, 0, 10, 0,             1, 0, 32'h11,       0);
    vecs[9]  = mk(1, 0, 10, 0,             1, 0, 11,   0,             0, 1, 1, 0, 10, 0,             0, 1, 0,            32'hA5A5_0002);
    vecs[10] = mk(1, 0, 11, 0,             1, 0, 11,   0,             1, 0, 1, 0, 11, 0,             1, 0, 32'hA5A5_0002, 0);
    vecs[11] = mk(1, 0, 11, 0,             1, 0, 10,   0,             0, 1, 1, 0, 11, 0,             0, 1, 0,            32'h11);
    vecs[12] = mk(0, 0, 0,  0,             1, 0, 10,   0,             0, 0, 1, 0, 10, 0,             1, 0, 32'h11,       0);
    vecs[13] = mk(0, 0, 0,  0,             0, 0, 0,    0,             0, 0, 0, 0, 0,  0,             0, 1, 0,            32'hA5A5_0002);
    vecs[14] = mk(0, 0, 0,  0,             1, 0, 5000, 0,             0, 0, 0, 0, 0,  0,             0, 0, 0,            0);
    vecs[15] = mk(0, 0, 0,  0,             0, 1, 8191, 32'hFFFF_FFFF, 0, 0, 0, 0, 0,  0,             0, 1, 0,            0);
    vecs[16] = mk(1, 1, 12, 32'h0000_00AB, 0, 0, 0,    0,             0, 0, 1, 1, 12, 32'h0000_00AB, 0, 0, 0,            0);
    vecs[17] = mk(0, 0, 0,  0,             0, 0, 0,    0,             0, 0, 0, 0, 0,  0,             0, 0, 0,            0);
    vecs[18] = mk(1, 0, 12, 0,             0, 0, 0,    0,             0, 0, 1, 0, 12, 0,             0, 0, 0,            0);
    vecs[19] = mk(0, 0, 0,  0,             0, 0, 0,    0,             0, 0, 0, 0, 0,  0,             1, 0, 32'hAB,       0);

    check("reset_busy", clear_busy, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      m0_read = vecs[i].m0_rd; m0_write = vecs[i].m0_wr;
      m0_address = vecs[i].m0_addr; m0_writedata = vecs[i].m0_wd;
      m1_read = vecs[i].m1_rd; m1_write = vecs[i].m1_wr;
      m1_address = vecs[i].m1_addr; m1_writedata = vecs[i].m1_wd;
      #2;
      check($sformatf("v%0d_wait0", i), m0_waitrequest, vecs[i].e_w0);
      check($sformatf("v%0d_wait1", i), m1_waitrequest, vecs[i].e_w1);
      check($sformatf("v%0d_cs", i), mem_chipselect, vecs[i].e_cs);
      if (vecs[i].e_cs) begin
        check($sformatf("v%0d_we", i), mem_write, vecs[i].e_we);
        check($sformatf("v%0d_addr", i), mem_address, vecs[i].e_addr);
        if (vecs[i].e_we) check($sformatf("v%0d_wd", i), mem_writedata, vecs[i].e_wd);
      end
      check($sformatf("v%0d_rv0", i), m0_readdatavalid, vecs[i].e_rv0);
      check($sformatf("v%0d_rv1", i), m1_readdatavalid, vecs[i].e_rv1);
      if (vecs[i].e_rv0) check($sformatf("v%0d_rd0", i), m0_readdata, vecs[i].e_rd0);
      if (vecs[i].e_rv1) check($sformatf("v%0d_rd1", i), m1_readdata, vecs[i].e_rd1);
    end
    check("ram10_final", ram[10], 32'hA5A5_0002);

    // Partial byte-lane write to the last implemented word, then read it back.
    @(negedge clk);
    idle_masters();
    m0_write = 1; m0_address = 13'd4999; m0_byteenable = 4'b0011; m0_writedata = 32'h1234_5678;
    #2 check("be_cs", mem_chipselect, 1);
    check("be_lanes", mem_byteenable, 4'b0011);
    @(negedge clk);
    idle_masters();
    m0_read = 1; m0_address = 13'd4999;
    #2 check("be_rd_same_cycle_rv", m0_readdatavalid, 0);
    @(negedge clk);
    idle_masters();
    #2 check("be_rv", m0_readdatavalid, 1);
    check("be_data", m0_readdata, 32'h0000_5678);
    @(negedge clk);
    #2 check("be_rv_drop", m0_readdatavalid, 0);

    // Fill, then clear with a read accepted in the clear_start cycle.
    m0_wr_cycle(13'd0, 32'hDEAD_BEEF);
    m0_wr_cycle(13'd2500, 32'h0000_2500);
    @(negedge clk);
    idle_masters();
    m0_read = 1; m0_address = 13'd2500; clear_start = 1;
    #2 check("cs_cycle_grant", m0_waitrequest, 0);
    @(negedge clk);
    clear_start = 0; m0_address = 13'd0;
    #2 check("cs_cycle_rv", m0_readdatavalid, 1);
    check("cs_cycle_rd", m0_readdata, 32'h0000_2500);
    check("clear_busy_on", clear_busy, 1);
    run_sweep(0, 50, 1'b1, n, bad);
    check("sweep_len", n, DEPTH);
    check("sweep_bad", bad, 0);
    check("post_clear_grant", m0_waitrequest, 0);
    @(negedge clk);
    m0_address = 13'd2500;
    #2 check("rd0_after_clear", m0_readdata, 0);
    check("rv0_after_clear", m0_readdatavalid, 1);
    @(negedge clk);
    m0_address = 13'd4999;
    #2 check("rd2500_after_clear", m0_readdata, 0);
    @(negedge clk);
    idle_masters();
    #2 check("rd4999_after_clear", m0_readdata, 0);
    check("rv4999_after_clear", m0_readdatavalid, 1);

    // Reset 100 cycles into a sweep, then tie-break and restart from address 0.
    @(negedge clk);
    clear_start = 1;
    @(negedge clk);
    clear_start = 0;
    repeat (99) @(negedge clk);
    #2 reset = 1;
    #1 check("rst_busy", clear_busy, 0);
    check("rst_cs", mem_chipselect, 0);
    @(negedge clk);
    reset = 0;
    m0_read = 1; m0_address = 13'd1; m1_read = 1; m1_address = 13'd2;
    #2 check("rst_tie_w0", m0_waitrequest, 0);
    check("rst_tie_w1", m1_waitrequest, 1);
    @(negedge clk);
    idle_masters();
    clear_start = 1;
    @(negedge clk);
    clear_start = 0;
    #2 check("restart_addr0", mem_address, 0);
    check("restart_busy", clear_busy, 1);
    run_sweep(0, -1, 1'b0, n, bad);
    check("restart_len", n, DEPTH);
    check("restart_bad", bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
